// File: rtl/jtag_er1_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// jtag_er1_cmd_ctrl
//
// Purpose
//   Sequences the ER1 user data register of the JTAGG primitive. Every
//   register here runs on JTCK.
//   - Capture-DR loads a status/response word into the shift register.
//   - Shift-DR moves that word out on tdo, LSB first, while a command
//     word moves in from tdi.
//   - Update-DR validates the shifted-in command. A good command goes to
//     the debug executor over a valid/ready handshake.
//
// Optional feature (compile-time macro JTAG_ER1_PARITY_EN)
//   Defined   : the shift register gains one MSB. That bit is an odd-parity
//               bit over the command. Update then requires DR_W+1 shifted
//               bits and odd parity across the whole register. A parity
//               failure sets status bit [4].
//   Undefined : the shift register is DR_W bits. Status bit [4] reads 0.
//
// Ports
//   JTCK          in   JTAG clock; sole clock
//   JRSTN         in   asynchronous active-low reset
//   debug_select  in   ER1 chain selected; gates every phase
//   capture_dr    in   Capture-DR strobe
//   shift_dr      in   Shift-DR strobe
//   update_dr     in   Update-DR strobe
//   tdi           in   serial data in
//   tdo           out  serial data out (shift register LSB)
//   cmd_valid     out  command offered downstream
//   cmd_ready     in   downstream accepts command
//   cmd_opcode    out  command opcode (0 = NOP, never issued)
//   cmd_data      out  command payload
//   rsp_valid     in   one-cycle response strobe
//   rsp_data      in   response data
//
// Capture word (MSB..LSB): [parity slot = 0] | status (OP_W) | rsp_buf (DATA_W)
//   Status bits:
//     [0] rsp_held
//     [1] cmd_valid
//     [2] overrun (sticky)
//     [3] length_err (sticky)
//     [4] parity_err (sticky)
//     [7:5] 0
// -----------------------------------------------------------------------------
module jtag_er1_cmd_ctrl #(
  parameter int OP_W   = 8,
  parameter int DATA_W = 24,
  parameter int DR_W   = OP_W + DATA_W
) (
  input  logic              JTCK,
  input  logic              JRSTN,
  input  logic              debug_select,
  input  logic              capture_dr,
  input  logic              shift_dr,
  input  logic              update_dr,
  input  logic              tdi,
  output logic              tdo,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [OP_W-1:0]   cmd_opcode,
  output logic [DATA_W-1:0] cmd_data,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data
);

`ifdef JTAG_ER1_PARITY_EN
  localparam int SR_W = DR_W + 1;
`else
  localparam int SR_W = DR_W;
`endif

  // Two spare codes above SR_W keep "too long" distinguishable from "exact".
  // The counter saturates, so a very long shift never wraps back to a legal
  // length.
  localparam int              CNT_W    = $clog2(DR_W + 2) + 1;
  localparam logic [CNT_W-1:0] CNT_GOOD = CNT_W'(SR_W);

  // Width of the status field actually carried in the capture word.
  // It is truncated if OP_W < 8 and zero-padded if OP_W > 8.
  localparam int ST_W = (OP_W < 8) ? OP_W : 8;

  // Phase decode with fixed priority: capture > shift > update.
  // Every phase is gated by debug_select.
  typedef enum logic [1:0] {
    PH_IDLE,
    PH_CAPTURE,
    PH_SHIFT,
    PH_UPDATE
  } phase_e;

  phase_e phase;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rsp_buf_q, rsp_buf_d;
  logic              rsp_held_q, rsp_held_d;
  logic              overrun_q, overrun_d;
  logic              len_err_q, len_err_d;
  logic              par_err_q, par_err_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [OP_W-1:0]   cmd_op_q, cmd_op_d;
  logic [DATA_W-1:0] cmd_data_q, cmd_data_d;

  // ---------------------------------------------------------------------------
  // Decode helpers
  // ---------------------------------------------------------------------------
  logic [7:0]        status;
  logic [OP_W-1:0]   status_f;
  logic [DR_W-1:0]   cap_word;
  logic [DR_W-1:0]   cmd_word;
  logic [OP_W-1:0]   upd_op;
  logic [DATA_W-1:0] upd_data;
  logic              len_ok;
  logic              parity_ok;
  logic              accept;

  always_comb begin
    phase = PH_IDLE;
    if (debug_select) begin
      if (capture_dr) begin
        phase = PH_CAPTURE;
      end else if (shift_dr) begin
        phase = PH_SHIFT;
      end else if (update_dr) begin
        phase = PH_UPDATE;
      end
    end
  end

  always_comb begin
    status = {3'b000, par_err_q, len_err_q, overrun_q, cmd_valid_q, rsp_held_q};

    status_f             = '0;
    status_f[ST_W-1:0]   = status[ST_W-1:0];

    cap_word = {status_f, rsp_buf_q};
  end

  assign cmd_word = sr_q[DR_W-1:0];
  assign upd_op   = cmd_word[DR_W-1 -: OP_W];
  assign upd_data = cmd_word[DATA_W-1:0];
  assign len_ok   = (cnt_q == CNT_GOOD);

`ifdef JTAG_ER1_PARITY_EN
  // Odd parity across the full register, including the parity bit.
  assign parity_ok = ^sr_q;
`else
  assign parity_ok = 1'b1;
`endif

  // The handshake completes in the same cycle it is observed.
  // This lets an update in that cycle reuse the slot.
  assign accept = cmd_valid_q & cmd_ready;

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    rsp_buf_d   = rsp_buf_q;
    rsp_held_d  = rsp_held_q;
    overrun_d   = overrun_q;
    len_err_d   = len_err_q;
    par_err_d   = par_err_q;
    cmd_valid_d = cmd_valid_q;
    cmd_op_d    = cmd_op_q;
    cmd_data_d  = cmd_data_q;

    if (accept) begin
      cmd_valid_d = 1'b0;
    end

    case (phase)
      PH_CAPTURE: begin
        // Zero-extension leaves the parity slot (if present) at 0.
        sr_d       = SR_W'(cap_word);
        cnt_d      = '0;
        // Status is read-to-clear.
        rsp_held_d = 1'b0;
        overrun_d  = 1'b0;
        len_err_d  = 1'b0;
        par_err_d  = 1'b0;
      end

      PH_SHIFT: begin
        sr_d = {tdi, sr_q[SR_W-1:1]};
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      PH_UPDATE: begin
        if (!len_ok) begin
          len_err_d = 1'b1;
        end else if (!parity_ok) begin
          par_err_d = 1'b1;
        end else if (upd_op != '0) begin
          if (cmd_valid_q && !accept) begin
            // Keep the pending command; flag the lost one.
            overrun_d = 1'b1;
          end else begin
            cmd_valid_d = 1'b1;
            cmd_op_d    = upd_op;
            cmd_data_d  = upd_data;
          end
        end
      end

      default: ;
    endcase

    // A response landing with capture wins over capture's clear of rsp_held.
    // The capture itself already sampled the old rsp_buf_q.
    if (rsp_valid) begin
      rsp_buf_d  = rsp_data;
      rsp_held_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge JTCK or negedge JRSTN) begin
    if (!JRSTN) begin
      sr_q        <= '0;
      cnt_q       <= '0;
      rsp_buf_q   <= '0;
      rsp_held_q  <= 1'b0;
      overrun_q   <= 1'b0;
      len_err_q   <= 1'b0;
      par_err_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= '0;
      cmd_data_q  <= '0;
    end else begin
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      rsp_buf_q   <= rsp_buf_d;
      rsp_held_q  <= rsp_held_d;
      overrun_q   <= overrun_d;
      len_err_q   <= len_err_d;
      par_err_q   <= par_err_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_data_q  <= cmd_data_d;
    end
  end

  assign tdo        = sr_q[0];
  assign cmd_valid  = cmd_valid_q;
  assign cmd_opcode = cmd_op_q;
  assign cmd_data   = cmd_data_q;

endmodule

// File: tb/tb_jtag_er1_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_jtag_er1_cmd_ctrl
//
// Self-checking bench for jtag_er1_cmd_ctrl (default OP_W=8, DATA_W=24).
//
// - A behavioural model tracks the data register as a plain bit vector, a
//   shift count, the flags and one pending command slot.
// - Every falling edge compares tdo and the command outputs with the model.
// - Directed scans pin the model with hand-computed literals.
// - A randomized phase follows the directed scans.
// -----------------------------------------------------------------------------
module tb_jtag_er1_cmd_ctrl;

`ifdef JTAG_ER1_PARITY_EN
  localparam bit PAR = 1'b1;
  localparam int SRW = 33;
`else
  localparam bit PAR = 1'b0;
  localparam int SRW = 32;
`endif

  localparam int CNT_MAX = (1 << ($clog2(32 + 2) + 1)) - 1;

  logic        JTCK         = 1'b0;
  logic        JRSTN        = 1'b0;
  logic        debug_select = 1'b0;
  logic        capture_dr   = 1'b0;
  logic        shift_dr     = 1'b0;
  logic        update_dr    = 1'b0;
  logic        tdi          = 1'b0;
  logic        cmd_ready    = 1'b0;
  logic        rsp_valid    = 1'b0;
  logic [23:0] rsp_data     = '0;

  logic        tdo;
  logic        cmd_valid;
  logic [7:0]  cmd_opcode;
  logic [23:0] cmd_data;

  jtag_er1_cmd_ctrl dut (
    .JTCK         (JTCK),
    .JRSTN        (JRSTN),
    .debug_select (debug_select),
    .capture_dr   (capture_dr),
    .shift_dr     (shift_dr),
    .update_dr    (update_dr),
    .tdi          (tdi),
    .tdo          (tdo),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_opcode   (cmd_opcode),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data)
  );

  always #5 JTCK = ~JTCK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [SRW-1:0] m_sr   = '0;
  int             m_cnt  = 0;
  logic [23:0]    m_rsp  = '0;
  logic [7:0]     m_op   = '0;
  logic [23:0]    m_data = '0;
  bit             m_held = 0;
  bit             m_ovr  = 0;
  bit             m_len  = 0;
  bit             m_par  = 0;
  bit             m_cv   = 0;

  initial begin
    forever begin
      bit          acc;
      bit          take;
      logic [7:0]  st;
      logic [31:0] cmdw;

      @(posedge JTCK or negedge JRSTN);

      if (!JRSTN) begin
        m_sr   = '0;
        m_cnt  = 0;
        m_rsp  = '0;
        m_op   = '0;
        m_data = '0;
        m_held = 0;
        m_ovr  = 0;
        m_len  = 0;
        m_par  = 0;
        m_cv   = 0;
      end else begin
        acc  = m_cv && cmd_ready;
        take = 0;
        cmdw = m_sr[31:0];

        if (debug_select && capture_dr) begin
          st         = {3'b000, m_par, m_len, m_ovr, m_cv, m_held};
          m_sr       = '0;
          m_sr[31:0] = {st, m_rsp};
          m_cnt      = 0;
          m_held     = 0;
          m_ovr      = 0;
          m_len      = 0;
          m_par      = 0;
        end else if (debug_select && shift_dr) begin
          m_sr          = m_sr >> 1;
          m_sr[SRW-1]   = tdi;
          if (m_cnt < CNT_MAX) begin
            m_cnt++;
          end
        end else if (debug_select && update_dr) begin
          if (m_cnt != SRW) begin
            m_len = 1;
          end else if (PAR && ((^m_sr) == 1'b0)) begin
            m_par = 1;
          end else if (cmdw[31:24] != 8'h00) begin
            if (m_cv && !acc) begin
              m_ovr = 1;
            end else begin
              take = 1;
            end
          end
        end

        if (acc) begin
          m_cv = 0;
        end

        if (take) begin
          m_cv   = 1;
          m_op   = cmdw[31:24];
          m_data = cmdw[23:0];
        end

        if (rsp_valid) begin
          m_rsp  = rsp_data;
          m_held = 1;
        end
      end
    end
  end

  // Output compare, half a cycle away from the active edge.
  initial begin
    forever begin
      @(negedge JTCK);
      chk("model tdo",        tdo,        m_sr[0]);
      chk("model cmd_valid",  cmd_valid,  m_cv);
      chk("model cmd_opcode", cmd_opcode, m_op);
      chk("model cmd_data",   cmd_data,   m_data);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  bit bg = 0;  // randomize handshake/response background when set

  task automatic tick();
    if (bg) begin
      cmd_ready = ($urandom_range(0, 3) == 0);
      rsp_valid = ($urandom_range(0, 7) == 0);
      rsp_data  = 24'($urandom);
    end
    @(posedge JTCK);
    #2;
  endtask

  function automatic logic [63:0] mkcmd(input logic [7:0] op, input logic [23:0] d,
                                        input bit good_par);
    logic [63:0] w;
    w = {32'h0, op, d};
    if (PAR) begin
      w[32] = good_par ? ~(^w[31:0]) : (^w[31:0]);
    end
    return w;
  endfunction

  // Capture, shift nbits (tdo sampled before each shift edge),
  // then optionally update.
  task automatic scan(input logic [63:0] din, input int nbits, input bit do_upd,
                      output logic [63:0] dout);
    dout = '0;

    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;

    for (int i = 0; i < nbits; i++) begin
      shift_dr = 1'b1;
      tdi      = din[i % 64];
      if (i < 64) begin
        dout[i] = tdo;
      end
      tick();
    end

    shift_dr = 1'b0;
    tdi      = 1'b0;

    if (do_upd) begin
      update_dr = 1'b1;
      tick();
      update_dr = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [63:0] d;

    debug_select = 1'b1;
    repeat (3) tick();
    chk("reset cmd_valid", cmd_valid, 1'b0);
    JRSTN = 1'b1;
    tick();
    chk("reset tdo",        tdo,        1'b0);
    chk("reset cmd_opcode", cmd_opcode, 8'h00);

    // Idle capture reads all zeros.
    scan('0, SRW, 0, d);
    chk("idle capture word", d[31:0], 32'h0000_0000);
    chk("idle cmd_valid",    cmd_valid, 1'b0);

    // Command issue, held while cmd_ready = 0.
    scan(mkcmd(8'h05, 24'h123456, 1), SRW, 1, d);
    chk("issue cmd_valid", cmd_valid,  1'b1);
    chk("issue opcode",    cmd_opcode, 8'h05);
    chk("issue data",      cmd_data,   24'h123456);
    repeat (3) tick();
    chk("hold cmd_valid", cmd_valid,  1'b1);
    chk("hold opcode",    cmd_opcode, 8'h05);

    // Overrun while pending.
    scan(mkcmd(8'h07, 24'h0ABCDE, 1), SRW, 1, d);
    chk("overrun keeps opcode", cmd_opcode, 8'h05);
    chk("overrun keeps data",   cmd_data,   24'h123456);
    scan('0, SRW, 0, d);
    chk("status overrun", d[31:24], 8'h06);
    scan('0, SRW, 0, d);
    chk("status overrun cleared", d[31:24], 8'h02);

    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("accept clears cmd_valid", cmd_valid, 1'b0);

    // Length errors: short, long, and saturated counter.
    scan(mkcmd(8'h05, 24'h111111, 1), SRW - 1, 1, d);
    chk("short no cmd", cmd_valid, 1'b0);
    scan('0, SRW, 0, d);
    chk("status short", d[31:24], 8'h08);

    scan(mkcmd(8'h05, 24'h111111, 1), SRW + 1, 1, d);
    chk("long no cmd", cmd_valid, 1'b0);
    scan('0, SRW, 0, d);
    chk("status long", d[31:24], 8'h08);

    scan(mkcmd(8'h05, 24'h111111, 1), 130, 1, d);
    chk("saturated no cmd", cmd_valid, 1'b0);
    scan('0, SRW, 0, d);
    chk("status saturated", d[31:24], 8'h08);

    // Response buffer and read-to-clear rsp_held.
    rsp_valid = 1'b1;
    rsp_data  = 24'hABCDEF;
    tick();
    rsp_valid = 1'b0;
    scan('0, SRW, 0, d);
    chk("rsp data",   d[23:0],  24'hABCDEF);
    chk("rsp status", d[31:24], 8'h01);
    scan('0, SRW, 0, d);
    chk("rsp held cleared", d[31:24], 8'h00);
    chk("rsp data kept",    d[23:0],  24'hABCDEF);

    // Response coinciding with capture.
    capture_dr = 1'b1;
    rsp_valid  = 1'b1;
    rsp_data   = 24'h135790;
    tick();
    capture_dr = 1'b0;
    rsp_valid  = 1'b0;
    chk("coincident capture old bit0", tdo, 1'b1);
    scan('0, SRW, 0, d);
    chk("coincident rsp status", d[31:24], 8'h01);
    chk("coincident rsp data",   d[23:0],  24'h135790);

    // Update in the same cycle as accept: no overrun.
    scan(mkcmd(8'h11, 24'h111111, 1), SRW, 1, d);
    scan(mkcmd(8'h22, 24'h222222, 1), SRW, 0, d);
    update_dr = 1'b1;
    cmd_ready = 1'b1;
    tick();
    update_dr = 1'b0;
    cmd_ready = 1'b0;
    chk("accept+update opcode", cmd_opcode, 8'h22);
    chk("accept+update valid",  cmd_valid,  1'b1);
    scan('0, SRW, 0, d);
    chk("accept+update status", d[31:24], 8'h02);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;

    // NOP does nothing.
    scan(mkcmd(8'h00, 24'h777777, 1), SRW, 1, d);
    chk("nop no cmd", cmd_valid, 1'b0);

    // Deselected chain ignores everything.
    debug_select = 1'b0;
    scan(mkcmd(8'h44, 24'h444444, 1), SRW, 1, d);
    chk("deselect no cmd", cmd_valid, 1'b0);
    debug_select = 1'b1;

    if (PAR) begin
      scan(mkcmd(8'h33, 24'h333333, 0), SRW, 1, d);
      chk("bad parity no cmd", cmd_valid, 1'b0);
      scan('0, SRW, 0, d);
      chk("status parity", d[31:24], 8'h10);
      chk("parity slot zero", d[32], 1'b0);

      scan(mkcmd(8'h33, 24'h333333, 1), SRW, 1, d);
      chk("good parity cmd", cmd_opcode, 8'h33);
      chk("good parity valid", cmd_valid, 1'b1);
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
    end

    // Randomized phase; the per-cycle compare does the checking.
    bg = 1;
    for (int t = 0; t < 300; t++) begin
      int          k;
      logic [7:0]  op;
      int          n;

      k = $urandom_range(0, 9);

      if (k == 0) begin
        for (int c = 0; c < 20; c++) begin
          debug_select = ($urandom_range(0, 9) != 0);
          capture_dr   = ($urandom_range(0, 5) == 0);
          shift_dr     = ($urandom_range(0, 1) == 0);
          update_dr    = ($urandom_range(0, 5) == 0);
          tdi          = 1'($urandom);
          tick();
        end
        debug_select = 1'b1;
        capture_dr   = 1'b0;
        shift_dr     = 1'b0;
        update_dr    = 1'b0;
      end else if (k == 1) begin
        capture_dr = 1'b1;
        tick();
        capture_dr = 1'b0;
        shift_dr   = 1'b1;
        repeat ($urandom_range(1, 20)) begin
          tdi = 1'($urandom);
          tick();
        end
        shift_dr = 1'b0;
        JRSTN    = 1'b0;
        tick();
        JRSTN    = 1'b1;
        tick();
      end else begin
        op = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        n  = ($urandom_range(0, 6) == 0) ? SRW - 1 + 2 * int'($urandom_range(0, 1)) : SRW;
        scan(mkcmd(op, 24'($urandom), $urandom_range(0, 6) != 0), n,
             $urandom_range(0, 9) != 0, d);
      end
    end

    bg        = 0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
